// File: rtl/float_to_twos.sv
// float_to_twos: expands {sign, exp, frac} into an OUT_W-bit two's-complement
// integer by shifting the significand left one bit per cycle, then applying
// the sign. Valid/ready handshake on both sides; one conversion in flight.
module float_to_twos #(
  parameter int EXP_W  = 3,
  parameter int FRAC_W = 4,
  // must hold FRAC_W + 2**EXP_W bits so the worst-case shift cannot overflow
  parameter int OUT_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W-1:0] in_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

  // working copy of the conversion in flight
  typedef struct packed {
    logic             sgn;
    logic [EXP_W-1:0] cnt;
    logic [OUT_W-1:0] mag;
  } conv_t;

  localparam logic [EXP_W-1:0] CNT_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0] MAG_ONE = {{(OUT_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;
  conv_t  cv;

  // status outputs are pure state decodes, so reset clears them immediately
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: accept in IDLE, shift until cnt hits 0, wait for consumer in OUT
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)        state_nxt = SHIFT;
      SHIFT:   if (cv.cnt == '0)    state_nxt = OUT;
      OUT:     if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // datapath: latch on accept, shift per cycle, sign-apply on the final edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv       <= '0;
      out_data <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          cv.sgn <= in_sign;
          cv.cnt <= in_exp;
          cv.mag <= {{(OUT_W-FRAC_W){1'b0}}, in_frac};
        end
        SHIFT: if (cv.cnt != '0) begin
          cv.mag <= cv.mag << 1;
          cv.cnt <= cv.cnt - CNT_ONE;
        end else begin
          // ~0+1 wraps to 0, so a negative zero comes out as plain zero
          out_data <= cv.sgn ? (~cv.mag + MAG_ONE) : cv.mag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_twos.sv
// Directed bench for float_to_twos: hand-computed vectors, latency, busy,
// backpressure and mid-conversion reset.
module tb_float_to_twos;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sign;
  logic [2:0]  in_exp;
  logic [3:0]  in_frac;
  logic        out_valid, out_ready, busy;
  logic [11:0] out_data;

  int checks = 0;
  int fails  = 0;

  float_to_twos #(.EXP_W(3), .FRAC_W(4), .OUT_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_frac(in_frac),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept one float, scramble inputs afterwards, check latency/busy/result
  task automatic convert(input string tag, input logic s, input logic [2:0] e,
                         input logic [3:0] f, input logic [11:0] exp_data);
    int  lat;
    bit  busy_ok;
    chk({tag, ".rdy"}, in_ready, 1'b1);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_frac = f;
    tick();
    in_valid = 1'b0; in_sign = ~s; in_exp = ~e; in_frac = ~f;
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 20) begin
      if (!busy || in_ready) busy_ok = 1'b0;
      tick();
      lat++;
    end
    chk({tag, ".lat"},  lat, e + 1);
    chk({tag, ".busy"}, busy_ok, 1'b1);
    chk({tag, ".data"}, out_data, exp_data);
  endtask

  // complete the output transfer (out_ready assumed high) and check IDLE
  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    chk({tag, ".vld0"}, out_valid, 1'b0);
    chk({tag, ".idle"}, in_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_frac = '0;
    out_ready = 1'b1;
    #12;
    chk("rst.rdy",  in_ready,  1'b1);
    chk("rst.vld",  out_valid, 1'b0);
    chk("rst.data", out_data,  12'h000);
    chk("rst.busy", busy,      1'b0);
    rst_n = 1'b1;
    tick();

    convert("zero",   1'b0, 3'd0, 4'h0,    12'h000); drain("zero");
    convert("e3",     1'b0, 3'd3, 4'b1011, 12'h058); drain("e3");
    convert("maxneg", 1'b1, 3'd7, 4'hF,    12'h880); drain("maxneg");
    convert("neg1",   1'b1, 3'd0, 4'h1,    12'hFFF); drain("neg1");
    convert("negz",   1'b1, 3'd5, 4'h0,    12'h000); drain("negz");
    convert("e7f1",   1'b0, 3'd7, 4'h1,    12'h080); drain("e7f1");

    // backpressure: result must hold, new inputs ignored
    out_ready = 1'b0;
    convert("bp", 1'b0, 3'd2, 4'h5, 12'h014);
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0]; in_sign = 1'b1; in_exp = 3'd1; in_frac = 4'h9;
      tick();
      chk("bp.vld",  out_valid, 1'b1);
      chk("bp.data", out_data,  12'h014);
      chk("bp.rdy",  in_ready,  1'b0);
    end
    in_valid = 1'b0;
    drain("bp");
    tick();
    chk("bp.nostart", busy, 1'b0);

    // reset three edges into a 6-shift conversion
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 3'd6; in_frac = 4'h7;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("mid.busy0", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.vld",  out_valid, 1'b0);
    chk("ar.busy", busy,      1'b0);
    chk("ar.rdy",  in_ready,  1'b1);
    #3 rst_n = 1'b1;
    tick();
    chk("ar.stay", busy, 1'b0);
    convert("post", 1'b0, 3'd1, 4'h3, 12'h006); drain("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/float_to_twos.md
Name: float_to_twos

Overview:
- Sequential decoder that converts the team's compact float format (sign, 3-bit exponent, 4-bit significand) back into a 12-bit two's-complement integer.
- It is the inverse path of the twos-to-float conversion chain, which uses leading-one detection to produce the exponent. This block instead re-expands the value by shifting the significand left exponent times, then applies the sign.
- Valid/ready on both sides, so it sits between a float source and the integer consumer or display logic.

Parameters:
- EXP_W, 3, exponent width; shift count ranges 0..2^EXP_W-1.
- FRAC_W, 4, significand width; unsigned, no hidden bit.
- OUT_W, 12, output width; must satisfy OUT_W >= FRAC_W + 2^EXP_W; 12 fits the largest magnitude, 1920.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input float is valid.
- in_ready  out  1  block can accept an input.
- in_sign  in  1  1 = negative.
- in_exp  in  EXP_W  left-shift count.
- in_frac  in  FRAC_W  unsigned significand.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  OUT_W  two's-complement result = (-1)^sign * frac * 2^exp.
- busy  out  1  high in SHIFT or OUT.

Behaviour:
- Reset (async, rst_n=0), effective immediately:
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0.
  - Internal magnitude, count and sign registers are cleared.
- States: IDLE, SHIFT, OUT.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch mag={zeros,in_frac} (OUT_W bits), cnt=in_exp, sgn=in_sign; go to SHIFT.
  - With in_valid=0: stay in IDLE.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge with cnt!=0: mag<=mag<<1, cnt<=cnt-1.
  - Edge with cnt==0: out_data <= sgn ? (~mag+1) : mag; out_valid<=1; go to OUT.
- OUT:
  - out_valid=1, out_data held stable, in_ready=0.
  - Edge with out_ready=1: out_valid<=0; go to IDLE. out_data keeps its last value and is don't-care while out_valid=0.
  - Edge with out_ready=0: hold everything.
- Latency: out_valid rises exp+1 edges after the acceptance edge, i.e. 1..8 cycles.
- Throughput: one conversion per exp+3 cycles minimum. in_ready is never high while out_valid is high, so input and output transfers never coincide.
- Arithmetic and width rules:
  - Shifting never overflows OUT_W, given the width constraint above.
  - Negation is an OUT_W-bit two's complement.
  - sign=1 with frac=0 yields 0, never a "negative zero" pattern.
  - exp=0 skips shifting; the result is ±frac.
- Inputs are sampled only on the acceptance edge; changes to in_* during SHIFT or OUT have no effect.
- Reset mid-SHIFT or mid-OUT aborts the conversion, drops out_valid asynchronously and discards the result. The first edge after rst_n returns high behaves as IDLE.
- out_ready held high in IDLE or SHIFT has no effect.

Test Plan:
- Reset, then S=0,E=0,F=0 with out_ready=1 -> out_valid 1 edge after accept, out_data=12'h000, back to IDLE, in_ready=1.
- S=0,E=3,F=4'b1011 -> out_data=12'h058 (88), out_valid exactly 4 edges after accept, busy high throughout.
- S=1,E=7,F=4'hF -> out_data=12'h880 (-1920) after 8 edges. Also S=1,E=0,F=4'h1 -> 12'hFFF.
- S=1,E=5,F=0 -> out_data=12'h000. Also S=0,E=7,F=1 -> 12'h080.
- Backpressure: S=0,E=2,F=5 with out_ready=0 for 6 cycles -> out_data=12'h014 held, out_valid=1, in_ready=0; in_valid pulses with new data are ignored. Raise out_ready -> one transfer, then IDLE.
- Drop rst_n mid-SHIFT (E=6 input, 3 edges in) -> out_valid=0, busy=0, in_ready=1 immediately. The next conversion S=0,E=1,F=3 -> 12'h006 correct.
